// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per clock, then sign fix-up.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO and divide-by-zero are handled here
// CALC  | WIDTH iterations, cnt runs WIDTH-1 down to 0
// SIGN  | sign correction of product or quotient/remainder, hi/lo written
// DONE  | hi/lo hold the result, done pulses
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   oper;
  logic [CNT_W-1:0]   cnt;
  logic               sign_a, sign_b, div_op;

  logic               accept, md_op, mt_op, op_div, b_zero, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept = (state == IDLE) && start && !flush;
  assign md_op  = !op[2];
  assign mt_op  = op[2] && !op[1];
  assign op_div = op[1];
  assign b_zero = (operandB == '0);
  assign a_neg  = op[0] && operandA[WIDTH-1];
  assign b_neg  = op[0] && operandB[WIDTH-1];
  assign a_mag  = a_neg ? -operandA : operandA;
  assign b_mag  = b_neg ? -operandB : operandB;

  // multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // divide: acc = {remainder, dividend bits / quotient bits}; rem_sub[WIDTH] is the borrow
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_sub  = rem_sh - {1'b0, oper};
  assign div_next = {rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0],
                     acc[WIDTH-2:0], ~rem_sub[WIDTH]};

  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (div_op) begin
      res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && md_op) state_nxt = (op_div && b_zero) ? DONE : CALC;
      CALC: begin
        if (flush)            state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = SIGN;
      end
      SIGN:    state_nxt = flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == SIGN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      oper      <= '0;
      cnt       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_op    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept && !(op[2] && op[1])) begin
          divByZero <= 1'b0;
          if (mt_op) begin
            if (op[0]) lo <= operandA;
            else       hi <= operandA;
          end else if (op_div && b_zero) begin
            hi        <= operandA;
            lo        <= '1;
            divByZero <= 1'b1;
          end else begin
            acc    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            oper   <= op_div ? b_mag : a_mag;
            cnt    <= CNT_W'(WIDTH - 1);
            sign_a <= a_neg;
            sign_b <= b_neg;
            div_op <= op_div;
          end
        end
        CALC: if (!flush) begin
          acc <= div_op ? div_next : mul_next;
          cnt <= cnt - CNT_W'(1);
        end
        SIGN: if (!flush) begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

  // the hazard unit must never issue while an operation is in flight
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy));

endmodule
